// File: rtl/mdu_scheduler_if.sv
// Controller-side request/status bundle for the multiply/divide scheduler.
// The controller drives requests (master); the scheduler answers (slave).
interface mdu_scheduler_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        req_ready;
  logic        mdu_busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        timeout_err;

  modport master (
    output req_valid, req_op, rs_val, rt_val,
    input  req_ready, mdu_busy, done, hi_out, lo_out, timeout_err
  );

  modport slave (
    input  req_valid, req_op, rs_val, rt_val,
    output req_ready, mdu_busy, done, hi_out, lo_out, timeout_err
  );
endinterface

// File: rtl/mdu_scheduler.sv
// Multiply/divide scheduler: accepts controller requests, pulses the start of
// one of four iterative units, waits on its busy flag and commits the result
// into the HI/LO registers it owns. mthi/mtlo are applied directly in IDLE.
//
// state  | meaning
// IDLE   | ready for a request; mthi/mtlo applied on accept
// LAUNCH | one-cycle start pulse to the selected unit, timer cleared
// WAIT   | polling busy of the selected unit, timer counting
// WB     | done pulse; HI/LO already hold the committed result
module mdu_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  mdu_scheduler_if.slave bus,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        mul_start_o,
  output logic        mulu_start_o,
  output logic        div_start_o,
  output logic        divu_start_o,
  input  logic [3:0]  unit_busy_i,
  input  logic [63:0] mul_res_i,
  input  logic [63:0] mulu_res_i,
  input  logic [31:0] div_q_i,
  input  logic [31:0] div_r_i,
  input  logic [31:0] divu_q_i,
  input  logic [31:0] divu_r_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;
  logic [3:0]  start;
  logic        done;

  // State and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state, HI/LO commit and start/done decode
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    start   = 4'b0000;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              // op[1:0] doubles as the unit index: mul, mulu, div, divu
              sel_d  = bus.req_op[1:0];
              op_a_d = bus.rs_val;
              op_b_d = bus.rt_val;
              // Divide by zero never starts a unit and leaves HI/LO untouched
              if (bus.req_op[1] && (bus.rt_val == 32'd0)) state_d = S_WB;
              else                                        state_d = S_LAUNCH;
            end
            3'b100:  hi_d = bus.rs_val;
            3'b101:  lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      S_LAUNCH: begin
        start[sel_q] = 1'b1;
        cnt_d        = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (!unit_busy_i[sel_q]) begin
          unique case (sel_q)
            2'd0: begin hi_d = mul_res_i[63:32];  lo_d = mul_res_i[31:0];  end
            2'd1: begin hi_d = mulu_res_i[63:32]; lo_d = mulu_res_i[31:0]; end
            2'd2: begin hi_d = div_r_i;           lo_d = div_q_i;          end
            2'd3: begin hi_d = divu_r_i;          lo_d = divu_q_i;         end
          endcase
          state_d = S_WB;
        end else begin
          if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
          // The TIMEOUT-th busy sample abandons the operation
          if (cnt_q >= CW'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.mdu_busy    = (state_q != S_IDLE);
  assign bus.done        = done;
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
  assign bus.timeout_err = terr_q;

  assign op_a_o       = op_a_q;
  assign op_b_o       = op_b_q;
  assign mul_start_o  = start[0];
  assign mulu_start_o = start[1];
  assign div_start_o  = start[2];
  assign divu_start_o = start[3];

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler with stubbed arithmetic units.
module tb_mdu_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op_a, op_b;
  logic        mul_start, mulu_start, div_start, divu_start;
  logic [3:0]  unit_busy = 4'b0000;
  logic [63:0] mul_res = '0, mulu_res = '0;
  logic [31:0] div_q = '0, div_r = '0, divu_q = '0, divu_r = '0;
  logic [3:0]  starts;
  int total = 0;
  int bad   = 0;

  mdu_scheduler_if bus ();

  mdu_scheduler #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .op_a_o       (op_a),
    .op_b_o       (op_b),
    .mul_start_o  (mul_start),
    .mulu_start_o (mulu_start),
    .div_start_o  (div_start),
    .divu_start_o (divu_start),
    .unit_busy_i  (unit_busy),
    .mul_res_i    (mul_res),
    .mulu_res_i   (mulu_res),
    .div_q_i      (div_q),
    .div_r_i      (div_r),
    .divu_q_i     (divu_q),
    .divu_r_i     (divu_r)
  );

  assign starts = {divu_start, div_start, mulu_start, mul_start};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.rs_val    = rs;
    bus.rt_val    = rt;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.rs_val    = '0;
    bus.rt_val    = '0;

    // reset
    tick(); tick();
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.mdu_busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_starts", starts, 0);
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_lo", bus.lo_out, 0);
    chk("rst_opa", op_a, 0);
    chk("rst_opb", op_b, 0);
    chk("rst_terr", bus.timeout_err, 0);
    rst = 1'b0;
    tick();

    // mul -3 * 5, unit busy cycles 2..5, other busy bits noisy at the end
    mul_res = 64'hFFFF_FFFF_FFFF_FFF1;
    req(3'b000, 32'hFFFF_FFFD, 32'd5);
    tick();                                         // cycle 1
    bus.req_valid = 1'b0;
    chk("mul_c1_starts", starts, 4'b0001);
    chk("mul_c1_busy", bus.mdu_busy, 1);
    chk("mul_c1_ready", bus.req_ready, 0);
    chk("mul_opa", op_a, 32'hFFFF_FFFD);
    chk("mul_opb", op_b, 32'd5);
    tick();                                         // cycle 2
    unit_busy = 4'b0001;
    chk("mul_c2_starts", starts, 0);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("mul_wait_done", bus.done, 0);
      chk("mul_wait_starts", starts, 0);
    end
    tick();                                         // cycle 6
    unit_busy = 4'b1110;
    chk("mul_c6_done", bus.done, 0);
    tick();                                         // cycle 7
    unit_busy = 4'b0000;
    chk("mul_c7_done", bus.done, 1);
    chk("mul_hi", bus.hi_out, 32'hFFFF_FFFF);
    chk("mul_lo", bus.lo_out, 32'hFFFF_FFF1);
    chk("mul_c7_ready", bus.req_ready, 0);
    tick();                                         // cycle 8
    chk("mul_c8_done", bus.done, 0);
    chk("mul_c8_ready", bus.req_ready, 1);

    // divu 100 / 7, unit never busy; div outputs carry decoys
    divu_q = 32'd14;  divu_r = 32'd2;
    div_q  = 32'hDEAD_0001; div_r = 32'hDEAD_0002;
    req(3'b011, 32'd100, 32'd7);
    tick();                                         // cycle 1
    bus.req_valid = 1'b0;
    chk("divu_c1_starts", starts, 4'b1000);
    tick();                                         // cycle 2
    chk("divu_c2_starts", starts, 0);
    chk("divu_c2_done", bus.done, 0);
    tick();                                         // cycle 3
    chk("divu_c3_done", bus.done, 1);
    chk("divu_lo", bus.lo_out, 32'd14);
    chk("divu_hi", bus.hi_out, 32'd2);
    tick();
    chk("divu_after_done", bus.done, 0);

    // mthi / mtlo, then reserved op
    req(3'b100, 32'h11, 32'h0);
    tick();
    chk("mthi_hi", bus.hi_out, 32'h11);
    chk("mthi_ready", bus.req_ready, 1);
    chk("mthi_done", bus.done, 0);
    req(3'b101, 32'h22, 32'h0);
    tick();
    chk("mtlo_lo", bus.lo_out, 32'h22);
    chk("mtlo_hi", bus.hi_out, 32'h11);
    req(3'b110, 32'h99, 32'h0);
    tick();
    chk("rsv_ready", bus.req_ready, 1);
    chk("rsv_busy", bus.mdu_busy, 0);
    chk("rsv_hi", bus.hi_out, 32'h11);
    chk("rsv_lo", bus.lo_out, 32'h22);

    // div by zero
    div_q = 32'h5555_5555; div_r = 32'h6666_6666;
    req(3'b010, 32'd9, 32'd0);
    tick();                                         // cycle 1
    bus.req_valid = 1'b0;
    chk("dz_done", bus.done, 1);
    chk("dz_starts", starts, 0);
    chk("dz_hi", bus.hi_out, 32'h11);
    chk("dz_lo", bus.lo_out, 32'h22);
    chk("dz_opa", op_a, 32'd9);
    tick();
    chk("dz_after_done", bus.done, 0);
    chk("dz_after_ready", bus.req_ready, 1);

    // mulu timeout: busy stuck, LAUNCH at cycle 1, WB at cycle 10
    mulu_res = 64'h1234_5678_9ABC_DEF0;
    req(3'b001, 32'd3, 32'd4);
    tick();                                         // cycle 1
    bus.req_valid = 1'b0;
    chk("to_c1_starts", starts, 4'b0010);
    unit_busy = 4'b0010;
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk("to_wait_done", bus.done, 0);
      chk("to_wait_terr", bus.timeout_err, 0);
    end
    tick();                                         // cycle 10
    chk("to_c10_done", bus.done, 1);
    chk("to_c10_terr", bus.timeout_err, 1);
    chk("to_hi", bus.hi_out, 32'h11);
    chk("to_lo", bus.lo_out, 32'h22);
    unit_busy = 4'b0000;
    tick();
    chk("to_after_done", bus.done, 0);
    chk("to_sticky", bus.timeout_err, 1);

    // signed div -20 / 6 with mthi held during the stall
    div_q = 32'hFFFF_FFFD; div_r = 32'hFFFF_FFFE;
    req(3'b010, 32'hFFFF_FFEC, 32'd6);
    tick();                                         // cycle 1
    req(3'b100, 32'h0000_ABCD, 32'd0);
    chk("st_c1_starts", starts, 4'b0100);
    chk("st_c1_ready", bus.req_ready, 0);
    tick();                                         // cycle 2
    unit_busy = 4'b0100;
    tick();                                         // cycle 3
    chk("st_c3_hi", bus.hi_out, 32'h11);
    tick();                                         // cycle 4
    unit_busy = 4'b0000;
    chk("st_c4_done", bus.done, 0);
    chk("st_c4_hi", bus.hi_out, 32'h11);
    tick();                                         // cycle 5
    chk("st_c5_done", bus.done, 1);
    chk("st_hi", bus.hi_out, 32'hFFFF_FFFE);
    chk("st_lo", bus.lo_out, 32'hFFFF_FFFD);
    chk("st_c5_ready", bus.req_ready, 0);
    tick();                                         // cycle 6: mthi accepted
    chk("st_c6_ready", bus.req_ready, 1);
    chk("st_c6_hi", bus.hi_out, 32'hFFFF_FFFE);
    tick();                                         // cycle 7
    bus.req_valid = 1'b0;
    chk("st_c7_hi", bus.hi_out, 32'h0000_ABCD);
    chk("st_terr_kept", bus.timeout_err, 1);

    // reset in the middle of WAIT
    mul_res = 64'hAAAA_BBBB_CCCC_DDDD;
    req(3'b000, 32'd7, 32'd8);
    tick();                                         // cycle 1
    bus.req_valid = 1'b0;
    tick();                                         // cycle 2
    unit_busy = 4'b0001;
    tick();                                         // cycle 3, WAIT
    chk("rw_busy_pre", bus.mdu_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    unit_busy = 4'b0000;
    chk("rw_ready", bus.req_ready, 1);
    chk("rw_busy", bus.mdu_busy, 0);
    chk("rw_done", bus.done, 0);
    chk("rw_hi", bus.hi_out, 0);
    chk("rw_lo", bus.lo_out, 0);
    chk("rw_terr", bus.timeout_err, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rw_no_done", bus.done, 0);
      chk("rw_no_start", starts, 0);
      chk("rw_hi_stays", bus.hi_out, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Sequences the multiply/divide resource for the multicycle CPU. Accepts mul/mulu/div/divu/mthi/mtlo requests from the main controller and issues one-cycle start pulses to the four iterative arithmetic units. It waits on the selected unit's busy, then commits results into the HI/LO registers it owns. It also provides stall, completion and fault status back to the controller.

## Interface
Parameters:
- TIMEOUT, 64, maximum WAIT cycles before the operation is abandoned (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request strobe from controller
- req_op  in  3  000 mul, 001 mulu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved
- rs_val  in  32  Rs operand
- rt_val  in  32  Rt operand (divisor for div/divu)
- req_ready  out  1  high only in IDLE
- mdu_busy  out  1  high in any state other than IDLE; controller stalls mfhi/mflo on it
- done  out  1  one-cycle completion pulse for mul/mulu/div/divu
- hi_out, lo_out  out  32 each  current HI/LO register contents
- op_a, op_b  out  32 each  operands latched at accept, held until IDLE
- mul_start, mulu_start, div_start, divu_start  out  1 each  one-cycle start pulses
- unit_busy  in  4  busy flags, bit order [3]=divu [2]=div [1]=mulu [0]=mul
- mul_res, mulu_res  in  64 each  product, valid when the matching busy bit is low
- div_q, div_r, divu_q, divu_r  in  32 each  quotient and remainder
- timeout_err  out  1  sticky fault flag

## Operation
- States: IDLE, LAUNCH, WAIT, WB. One-hot or binary encoding is acceptable.
- Accept = req_valid & req_ready. Requests while not ready are ignored; the controller holds them.
- IDLE, accepting mthi/mtlo:
  - HI or LO is written with rs_val on the accept edge.
  - State stays IDLE and done is not asserted.
- IDLE, accepting a reserved op: no effect and stays IDLE.
- IDLE, accepting mul/mulu/div/divu:
  - Latch op, op_a=rs_val and op_b=rt_val.
  - Register sel = unit index.
  - Next state is LAUNCH, except div/divu with rt_val==0, which goes directly to WB with no start pulse and HI/LO unchanged.
- LAUNCH:
  - Exactly the selected start output is high for this one cycle.
  - Clear the timeout counter. Next state is WAIT.
- WAIT: sample unit_busy[sel].
  - If low, commit results and go to WB:
    - mul/mulu: HI=res[63:32], LO=res[31:0].
    - div/divu: LO=q, HI=r, as 32-bit two's-complement patterns taken from the unit.
  - If high, increment the counter. When the counter reaches TIMEOUT, go to WB without writing HI/LO and set timeout_err.
- WB: done=1. Next state is IDLE.
- unit_busy bits other than sel are ignored.
- timeout_err clears only on rst.
- Timeout counter width is clog2(TIMEOUT+1). The counter saturates and does not wrap.

## Timing
- Reset values:
  - State IDLE and req_ready=1.
  - mdu_busy=0 and done=0.
  - All start outputs 0.
  - hi_out=lo_out=0 and op_a=op_b=0.
  - timeout_err=0 and counter=0.
- Accept at cycle 0 gives LAUNCH at cycle 1, with start high in cycle 1 only.
- The unit may raise busy from cycle 2. WAIT begins at cycle 2.
- A unit that never raises busy has busy sampled low at cycle 2, so WB is cycle 3. This 3-cycle minimum applies from accept to done.
- For a unit busy through cycle k (k≥2), busy is first low at cycle k+1 and WB is at cycle k+2.
- New hi_out/lo_out values are visible in the WB cycle, coincident with done.
- Divide-by-zero: WB at cycle 1, done at cycle 1, no start pulse.
- Timeout: WB occurs TIMEOUT+1 cycles after LAUNCH; timeout_err is high from the WB cycle onward.
- req_ready returns high the cycle after WB, so back-to-back ops have a 1-cycle gap minimum.
- mthi/mtlo takes effect on the accept edge and is readable on the next cycle.
- rst asserted in any state returns everything to reset values on that edge:
  - No pending start or done is emitted.
  - Subsequent unit results are ignored.

## Test plan
- mul, rs=0xFFFFFFFD (−3), rt=5, with a stub busy for 4 cycles:
  - mul_start is pulsed once in cycle 1.
  - WB/done at cycle 7.
  - hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1.
- divu, rs=100, rt=7, with a stub that never raises busy:
  - done at cycle 3.
  - lo_out=14, hi_out=2.
  - div_start stays 0 and divu_start pulses once.
- div by zero after mthi 0x11 and mtlo 0x22, with rs=9, rt=0:
  - No start pulse.
  - done at cycle 1.
  - HI=0x11, LO=0x22 unchanged.
- TIMEOUT=8 with busy stuck high on mulu:
  - WB 9 cycles after LAUNCH.
  - HI/LO unchanged.
  - timeout_err=1 and stays 1 until rst.
- Stall and reset:
  - mthi held valid during an in-flight div is not accepted while req_ready=0, and is applied the cycle after done.
  - rst asserted mid-WAIT gives IDLE next cycle, HI/LO=0, no done pulse.
